// File: rtl/traffic_phase_seq_if.sv
// Sensor inputs and decoder-facing outputs of the traffic phase sequencer.
// master = sequencer side, slave = sensor/decoder side.
interface traffic_phase_seq_if;
  logic        car_in;
  logic        line_in;
  logic [31:0] counter;
  logic [31:0] car_num;
  logic        line_sen;
  logic [7:0]  sec_left;

  modport master (
    input  car_in, line_in,
    output counter, car_num, line_sen, sec_left
  );

  modport slave (
    output car_in, line_in,
    input  counter, car_num, line_sen, sec_left
  );
endinterface

// File: rtl/traffic_phase_seq.sv
// One-second tick phase sequencer (red/yellow/green/yellow) with car counting and yellow-phase
// stop-line violation latch. Optional green extension: define TRAFFIC_GREEN_EXT_EN.
module traffic_phase_seq #(
  parameter int unsigned CLK_PER_SEC = 50_000_000,
  parameter int unsigned RED_SEC     = 10,
  parameter int unsigned YEL_SEC     = 2,
  parameter int unsigned GRN_SEC     = 10,
  parameter int unsigned CAR_THRESH  = 8,
  parameter int unsigned EXT_SEC     = 5,
  parameter logic [31:0] CNT_INIT    = 32'd0
) (
  input  logic                clk,
  input  logic                rst,
  traffic_phase_seq_if.master bus
);

  localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;

  typedef enum logic [1:0] {
    PH_RED  = 2'd0,
    PH_YEL1 = 2'd1,
    PH_GRN  = 2'd2,
    PH_YEL2 = 2'd3
  } phase_e;

  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   counter_q, counter_d;
  logic [31:0]   car_num_q, car_num_d;
  logic          line_sen_q, line_sen_d;
  logic [7:0]    sec_left_q, sec_left_d;
  logic          car_s1_q, car_s2_q, car_prev_q, car_edge_q;
  logic          line_s1_q, line_s2_q;
  logic          tick;
  logic          advance;
  phase_e        phase, phase_next;

`ifdef TRAFFIC_GREEN_EXT_EN
  logic          ext_q, ext_d;
`else
  logic          unused_cfg;
  assign unused_cfg = ^{CAR_THRESH[0], EXT_SEC[0]};
`endif

  function automatic logic [7:0] phase_dur(phase_e p);
    case (p)
      PH_RED:  phase_dur = 8'(RED_SEC);
      PH_GRN:  phase_dur = 8'(GRN_SEC);
      default: phase_dur = 8'(YEL_SEC);
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q    <= '0;
      counter_q  <= CNT_INIT;
      car_num_q  <= '0;
      line_sen_q <= 1'b0;
      sec_left_q <= 8'(RED_SEC);
      car_s1_q   <= 1'b0;
      car_s2_q   <= 1'b0;
      car_prev_q <= 1'b0;
      car_edge_q <= 1'b0;
      line_s1_q  <= 1'b0;
      line_s2_q  <= 1'b0;
`ifdef TRAFFIC_GREEN_EXT_EN
      ext_q      <= 1'b0;
`endif
    end else begin
      presc_q    <= presc_d;
      counter_q  <= counter_d;
      car_num_q  <= car_num_d;
      line_sen_q <= line_sen_d;
      sec_left_q <= sec_left_d;
      car_s1_q   <= bus.car_in;
      car_s2_q   <= car_s1_q;
      car_prev_q <= car_s2_q;
      // Registered edge pulse keeps the sensor path fully isolated from car_num.
      car_edge_q <= car_s2_q & ~car_prev_q;
      line_s1_q  <= bus.line_in;
      line_s2_q  <= line_s1_q;
`ifdef TRAFFIC_GREEN_EXT_EN
      ext_q      <= ext_d;
`endif
    end
  end

  always_comb begin
    tick       = (presc_q == PW'(CLK_PER_SEC - 1));
    presc_d    = tick ? '0 : presc_q + 1'b1;
    phase      = phase_e'(counter_q[1:0]);
    advance    = 1'b0;
    sec_left_d = sec_left_q;
`ifdef TRAFFIC_GREEN_EXT_EN
    ext_d      = ext_q;
`endif

    if (tick) begin
      if (sec_left_q > 8'd1) begin
        sec_left_d = sec_left_q - 8'd1;
      end
`ifdef TRAFFIC_GREEN_EXT_EN
      else if (phase == PH_GRN && car_num_q >= CAR_THRESH && !ext_q) begin
        sec_left_d = 8'(EXT_SEC);
        ext_d      = 1'b1;
      end
`endif
      else begin
        advance = 1'b1;
      end
    end

    counter_d  = counter_q + {31'd0, advance};
    phase_next = phase_e'(counter_d[1:0]);
    if (advance) begin
      sec_left_d = phase_dur(phase_next);
`ifdef TRAFFIC_GREEN_EXT_EN
      ext_d      = 1'b0;
`endif
    end

    if (advance) begin
      line_sen_d = (phase_next == PH_YEL1 || phase_next == PH_YEL2) && line_s2_q;
    end else if (phase == PH_YEL1 || phase == PH_YEL2) begin
      line_sen_d = line_sen_q | line_s2_q;
    end else begin
      line_sen_d = 1'b0;
    end

    // A car edge coinciding with red entry counts as the first car of the new cycle.
    if (advance && phase_next == PH_RED) begin
      car_num_d = {31'd0, car_edge_q};
    end else if (car_edge_q && car_num_q != 32'hFFFF_FFFF) begin
      car_num_d = car_num_q + 32'd1;
    end else begin
      car_num_d = car_num_q;
    end
  end

  assign bus.counter  = counter_q;
  assign bus.car_num  = car_num_q;
  assign bus.line_sen = line_sen_q;
  assign bus.sec_left = sec_left_q;

endmodule

// File: tb/tb_traffic_phase_seq.sv
// Bench for traffic_phase_seq: a time-based reference model (phase start edge + elapsed
// cycles, sensor sample history) is compared with the DUT after every clock edge.
`timescale 1ns/1ps
module tb_traffic_phase_seq;
  localparam int C      = 4;
  localparam int RED    = 10;
  localparam int YEL    = 2;
  localparam int GRN    = 10;
  localparam int THRESH = 3;
  localparam int EXT    = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0, w_rst = 1'b0;
  logic car_drv = 1'b0, line_drv = 1'b0, w_car = 1'b0;

  traffic_phase_seq_if tif();
  traffic_phase_seq_if wif();
  assign tif.car_in  = car_drv;
  assign tif.line_in = line_drv;
  assign wif.car_in  = w_car;
  assign wif.line_in = 1'b0;

  traffic_phase_seq #(
    .CLK_PER_SEC(C), .RED_SEC(RED), .YEL_SEC(YEL), .GRN_SEC(GRN),
    .CAR_THRESH(THRESH), .EXT_SEC(EXT), .CNT_INIT(32'd0)
  ) dut (.clk(clk), .rst(rst), .bus(tif.master));

  traffic_phase_seq #(
    .CLK_PER_SEC(1), .RED_SEC(1), .YEL_SEC(1), .GRN_SEC(1),
    .CAR_THRESH(THRESH), .EXT_SEC(EXT), .CNT_INIT(32'hFFFF_FFF0)
  ) dut_w (.clk(clk), .rst(w_rst), .bus(wif.master));

  int n_total = 0, n_pass = 0;

  // Reference model state
  int          m_t, m_start, m_dur;
  bit          m_ext;
  logic [31:0] m_cnt, m_car;
  logic        m_line;
  bit          ch[1:4];
  bit          lh[1:2];

  function automatic int phase_dur(int p);
    return (p == 0) ? RED : (p == 2) ? GRN : YEL;
  endfunction

  task automatic model_edge(input bit rs, input bit cs, input bit ls);
    bit cedge, chg;
    int ph, np;
    if (rs) begin
      m_t = 0; m_start = 0; m_dur = RED; m_ext = 0;
      m_cnt = 0; m_car = 0; m_line = 0;
      for (int i = 1; i <= 4; i++) ch[i] = 0;
      lh[1] = 0; lh[2] = 0;
      return;
    end
    m_t++;
    cedge = ch[3] && !ch[4];
    ph = int'(m_cnt % 4);
    chg = 0;
    if (m_t - m_start == m_dur * C) begin
`ifdef TRAFFIC_GREEN_EXT_EN
      if (ph == 2 && !m_ext && m_car >= THRESH) begin
        m_dur += EXT;
        m_ext = 1;
      end else chg = 1;
`else
      chg = 1;
`endif
    end
    if (chg) begin
      m_cnt++;
      m_start = m_t;
      np = int'(m_cnt % 4);
      m_dur = phase_dur(np);
      m_ext = 0;
      m_line = (np % 2 == 1) && lh[2];
      if (np == 0) m_car = 32'(cedge);
      else if (cedge && m_car != 32'hFFFF_FFFF) m_car++;
    end else begin
      m_line = (ph % 2 == 1) ? (m_line || lh[2]) : 1'b0;
      if (cedge && m_car != 32'hFFFF_FFFF) m_car++;
    end
    ch[4] = ch[3]; ch[3] = ch[2]; ch[2] = ch[1]; ch[1] = cs;
    lh[2] = lh[1]; lh[1] = ls;
  endtask

  function automatic logic [72:0] exp_vec();
    return {m_cnt, m_car, m_line, 8'(m_dur - (m_t - m_start) / C)};
  endfunction

  function automatic logic [72:0] dut_vec();
    return {tif.counter, tif.car_num, tif.line_sen, tif.sec_left};
  endfunction

  task automatic tick_edge();
    @(posedge clk);
    model_edge(rst, car_drv, line_drv);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick_edge();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; car_drv = 1'b1; line_drv = 1'b1;
    tick_edge();
    rst = 1'b0; car_drv = 1'b0; line_drv = 1'b0;
    n_total++;
    if (dut_vec() !== {32'd0, 32'd0, 1'b0, 8'd10})
      $display("FAIL reset_state got cnt=%0d car=%0d line=%0b sec=%0d want 0/0/0/10",
               tif.counter, tif.car_num, tif.line_sen, tif.sec_left);
    else n_pass++;
  endtask

  task automatic test_phase_timing();
    logic [31:0] want;
    do_reset();
    for (int i = 1; i <= 100; i++) begin
      tick_edge();
      n_total++;
      if (dut_vec() !== exp_vec())
        $display("FAIL phase_model t=%0d got %h want %h", m_t, dut_vec(), exp_vec());
      else n_pass++;
      if (i == 40 || i == 48 || i == 88 || i == 96) begin
        want = (i == 40) ? 32'd1 : (i == 48) ? 32'd2 : (i == 88) ? 32'd3 : 32'd4;
        n_total++;
        if (tif.counter !== want)
          $display("FAIL phase_edge t=%0d got counter=%0d want %0d", i, tif.counter, want);
        else n_pass++;
      end
    end
  endtask

  task automatic test_cars();
    do_reset();
    for (int i = 1; i <= 110; i++) begin
      car_drv = (i >= 3 && i < 28 && (i - 3) % 5 < 3) || (i >= 93 && i <= 95);
      tick_edge();
      n_total++;
      if (dut_vec() !== exp_vec())
        $display("FAIL car_model t=%0d got %h want %h", m_t, dut_vec(), exp_vec());
      else n_pass++;
      if (i == 40) begin
        n_total++;
        if (tif.car_num !== 32'd5)
          $display("FAIL car_count_five got %0d want 5", tif.car_num);
        else n_pass++;
      end
      if (i == 96) begin
        n_total++;
        if ({tif.counter, tif.car_num} !== {32'd4, 32'd1})
          $display("FAIL car_red_entry got cnt=%0d car=%0d want cnt=4 car=1",
                   tif.counter, tif.car_num);
        else n_pass++;
      end
    end
    car_drv = 1'b0;
  endtask

  task automatic test_line();
    do_reset();
    for (int i = 1; i <= 100; i++) begin
      line_drv = 1'b1;
      tick_edge();
      n_total++;
      if (dut_vec() !== exp_vec())
        $display("FAIL line_hold_model t=%0d got %h want %h", m_t, dut_vec(), exp_vec());
      else n_pass++;
      if (i == 40 || i == 47 || i == 48 || i == 88 || i == 96) begin
        n_total++;
        if (tif.line_sen !== ((i == 48 || i == 96) ? 1'b0 : 1'b1))
          $display("FAIL line_hold_phase t=%0d got line_sen=%0b cnt=%0d", i,
                   tif.line_sen, tif.counter);
        else n_pass++;
      end
    end
    do_reset();
    for (int i = 1; i <= 60; i++) begin
      line_drv = (i == 43 || i == 44);
      tick_edge();
      n_total++;
      if (dut_vec() !== exp_vec())
        $display("FAIL line_pulse_model t=%0d got %h want %h", m_t, dut_vec(), exp_vec());
      else n_pass++;
      if (i == 46 || i == 48) begin
        n_total++;
        if ({tif.counter, tif.line_sen} !== ((i == 46) ? {32'd1, 1'b1} : {32'd2, 1'b0}))
          $display("FAIL line_pulse t=%0d got cnt=%0d line_sen=%0b", i, tif.counter,
                   tif.line_sen);
        else n_pass++;
      end
    end
    line_drv = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit found;
    int edges;
    do_reset();
    found = 0;
    for (int i = 1; i <= 200 && !found; i++) begin
      car_drv = (i >= 5 && i <= 7);
      tick_edge();
      n_total++;
      if (dut_vec() !== exp_vec())
        $display("FAIL rstmid_model t=%0d got %h want %h", m_t, dut_vec(), exp_vec());
      else n_pass++;
      if (tif.counter == 32'd2 && tif.sec_left == 8'd6) found = 1;
    end
    car_drv = 1'b0;
    n_total++;
    if (!found) $display("FAIL rstmid_reach got no green sec_left=6 want reached in 200 edges");
    else n_pass++;
    do_reset();
    n_total++;
    if ({tif.counter, tif.car_num, tif.sec_left} !== {32'd0, 32'd0, 8'd10})
      $display("FAIL rstmid_state got cnt=%0d car=%0d sec=%0d want 0/0/10",
               tif.counter, tif.car_num, tif.sec_left);
    else n_pass++;
    edges = 0;
    for (int i = 1; i <= 100 && edges == 0; i++) begin
      tick_edge();
      if (tif.counter != 32'd0) edges = i;
    end
    n_total++;
    if (edges != 40) $display("FAIL rstmid_first_change got %0d edges want 40", edges);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 3) == 0) car_drv = ~car_drv;
      if ($urandom_range(0, 9) == 0) line_drv = ~line_drv;
      tick_edge();
      rst = 1'b0;
      n_total++;
      if (dut_vec() !== exp_vec())
        $display("FAIL random_model t=%0d got %h want %h", m_t, dut_vec(), exp_vec());
      else n_pass++;
    end
    car_drv = 1'b0; line_drv = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] want_cnt, want_car;
    w_rst = 1'b1; w_car = 1'b0;
    tick_edge();
    w_rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      w_car = (k >= 11);
      tick_edge();
      want_cnt = 32'hFFFF_FFF0 + 32'(k);
      n_total++;
      if ({wif.counter, wif.sec_left} !== {want_cnt, 8'd1})
        $display("FAIL wrap_counter k=%0d got cnt=%h sec=%0d want cnt=%h sec=1", k,
                 wif.counter, wif.sec_left, want_cnt);
      else n_pass++;
      if (k >= 13 && k <= 16) begin
        want_car = (k == 14 || k == 15) ? 32'd1 : 32'd0;
        n_total++;
        if (wif.car_num !== want_car)
          $display("FAIL wrap_car_num k=%0d got %0d want %0d", k, wif.car_num, want_car);
        else n_pass++;
      end
    end
    w_car = 1'b0;
  endtask

`ifdef TRAFFIC_GREEN_EXT_EN
  task automatic test_green_ext();
    int ncars, want, hit;
    for (int s = 0; s < 2; s++) begin
      ncars = (s == 0) ? 4 : 2;
      want  = (s == 0) ? 108 : 88;
      do_reset();
      hit = 0;
      for (int i = 1; i <= 140 && hit == 0; i++) begin
        car_drv = (i >= 3 && i < 3 + 5 * ncars && (i - 3) % 5 < 3);
        tick_edge();
        n_total++;
        if (dut_vec() !== exp_vec())
          $display("FAIL ext_model t=%0d got %h want %h", m_t, dut_vec(), exp_vec());
        else n_pass++;
        if (tif.counter == 32'd3) hit = i;
      end
      car_drv = 1'b0;
      n_total++;
      if (hit != want)
        $display("FAIL ext_green_len cars=%0d got counter=3 at %0d want %0d", ncars, hit, want);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_phase_timing();
    test_cars();
    test_line();
    test_reset_mid();
    test_wrap();
`ifdef TRAFFIC_GREEN_EXT_EN
    test_green_ext();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
